// File: rtl/fpga_status_led_ctrl.sv
// Board status-LED controller: heartbeat, alive indicator, sticky exit status, blink-code readout.
// Optional LED_PWM_DIM_EN adds registered PWM dimming of every led_o bit from duty_i.
module fpga_status_led_ctrl #(
   parameter int CLK_LED_COUNT_LENGTH = 27,
   parameter int NUM_LEDS             = 4,
   parameter int EXIT_WIDTH           = 32,
   parameter int PWM_WIDTH            = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  exit_valid_i,
   input  logic [EXIT_WIDTH-1:0] exit_value_i,
   input  logic                  clear_i,
   input  logic [PWM_WIDTH-1:0]  duty_i,
   output logic [NUM_LEDS-1:0]   led_o,
   output logic                  exit_value_o,
   output logic [1:0]            state_o,
   output logic                  tick_o
);

   localparam int L = CLK_LED_COUNT_LENGTH;
   // Keep only the code bits anything looks at: the blink nibble and the mirrored LED bits.
   localparam int CODE_W = (NUM_LEDS - 3 > 4) ? NUM_LEDS - 3 : 4;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [L-1:0]        cnt_q;
   logic                alive_q;
   logic                exit_valid_q;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                on_q, on_d;
   logic                pausing_q, pausing_d;
   logic [4:0]          pulse_q, pulse_d;
   logic [2:0]          pause_q, pause_d;

   logic                tick;
   logic                rise;
   logic [4:0]          n_pulses;
   logic [NUM_LEDS-1:0] led_raw;

   assign tick     = &cnt_q[L-3:0];
   assign rise     = exit_valid_i & ~exit_valid_q;
   assign n_pulses = (code_q[3:0] == 4'd0) ? 5'd16 : {1'b0, code_q[3:0]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q        <= '0;
         alive_q      <= 1'b0;
         exit_valid_q <= 1'b0;
         state_q      <= ST_RUN;
         code_q       <= '0;
         on_q         <= 1'b0;
         pausing_q    <= 1'b0;
         pulse_q      <= '0;
         pause_q      <= '0;
      end else begin
         cnt_q        <= cnt_q + 1'b1;
         alive_q      <= 1'b1;
         exit_valid_q <= exit_valid_i;
         state_q      <= state_d;
         code_q       <= code_d;
         on_q         <= on_d;
         pausing_q    <= pausing_d;
         pulse_q      <= pulse_d;
         pause_q      <= pause_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      code_d    = code_q;
      on_d      = on_q;
      pausing_d = pausing_q;
      pulse_d   = pulse_q;
      pause_d   = pause_q;

      case (state_q)
         ST_RUN: begin
            if (rise) begin
               state_d = (exit_value_i == '0) ? ST_PASS : ST_FAIL;
               code_d  = exit_value_i[CODE_W-1:0];
            end
         end
         ST_PASS: ;
         ST_FAIL: begin
            // One slot per tick: N x (ON, OFF), then four OFF pause slots.
            if (tick) begin
               if (on_q) begin
                  on_d = 1'b0;
               end else if (pausing_q) begin
                  if (pause_q == 3'd3) begin
                     pausing_d = 1'b0;
                     pause_d   = '0;
                     on_d      = 1'b1;
                     pulse_d   = 5'd1;
                  end else begin
                     pause_d = pause_q + 3'd1;
                  end
               end else if (pulse_q == n_pulses) begin
                  pausing_d = 1'b1;
                  pause_d   = '0;
                  pulse_d   = '0;
               end else begin
                  on_d    = 1'b1;
                  pulse_d = pulse_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
            code_d  = '0;
         end
      endcase

      if (state_q != ST_FAIL || clear_i) begin
         on_d      = 1'b0;
         pausing_d = 1'b0;
         pulse_d   = '0;
         pause_d   = '0;
      end

      if (clear_i) begin
         state_d = ST_RUN;
         code_d  = '0;
      end
   end

   always_comb begin
      led_raw    = '0;
      led_raw[0] = cnt_q[L-1];
      led_raw[1] = alive_q;
      led_raw[2] = (state_q == ST_PASS) | ((state_q == ST_FAIL) & on_q);
      for (int k = 3; k < NUM_LEDS; k++) begin
         led_raw[k] = code_q[k-3];
      end
   end

   assign exit_value_o = code_q[0];
   assign state_o      = state_q;
   assign tick_o       = tick;

`ifdef LED_PWM_DIM_EN
   logic [PWM_WIDTH-1:0] pwm_cnt_q;
   logic [NUM_LEDS-1:0]  led_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwm_cnt_q <= '0;
         led_q     <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_q + 1'b1;
         led_q     <= led_raw & {NUM_LEDS{pwm_cnt_q < duty_i}};
      end
   end

   assign led_o = led_q;
`else
   logic unused_duty;
   assign unused_duty = ^duty_i;
   assign led_o       = led_raw;
`endif

endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// Bench for fpga_status_led_ctrl: directed steps plus random exit codes against a tick-count model.
module tb_fpga_status_led_ctrl;

   localparam int L  = 6;
   localparam int NL = 6;
   localparam int EW = 32;
   localparam int PW = 8;

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b1;
   logic          exit_valid = 1'b0;
   logic [EW-1:0] exit_value = '0;
   logic          clear      = 1'b0;
   logic [PW-1:0] duty       = '1;
   logic [NL-1:0] led_o;
   logic          exit_value_o;
   logic [1:0]    state_o;
   logic          tick_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpga_status_led_ctrl #(
      .CLK_LED_COUNT_LENGTH(L),
      .NUM_LEDS            (NL),
      .EXIT_WIDTH          (EW),
      .PWM_WIDTH           (PW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .exit_valid_i (exit_valid),
      .exit_value_i (exit_value),
      .clear_i      (clear),
      .duty_i       (duty),
      .led_o        (led_o),
      .exit_value_o (exit_value_o),
      .state_o      (state_o),
      .tick_o       (tick_o)
   );

   // Reference model: clock edges since release, sticky status, ticks seen while failing.
   int            m_cyc   = 0;
   bit            m_alive = 1'b0;
   bit            m_prev  = 1'b0;
   int            m_state = 0;
   logic [EW-1:0] m_code  = '0;
   int            m_ticks = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc   <= 0;
         m_alive <= 1'b0;
         m_prev  <= 1'b0;
         m_state <= 0;
         m_code  <= '0;
         m_ticks <= 0;
      end else begin
         m_cyc   <= m_cyc + 1;
         m_alive <= 1'b1;
         m_prev  <= exit_valid;
         if (clear) begin
            m_state <= 0;
            m_code  <= '0;
            m_ticks <= 0;
         end else if (m_state == 0 && exit_valid && !m_prev) begin
            m_state <= (exit_value == 0) ? 1 : 2;
            m_code  <= exit_value;
            m_ticks <= 0;
         end else if (m_state == 2 && (m_cyc % 16) == 15) begin
            m_ticks <= m_ticks + 1;
         end
      end
   end

   function automatic bit blink_exp(int k, logic [3:0] nib);
      int n;
      int p;
      n = (nib == 4'd0) ? 16 : int'(nib);
      if (k == 0) return 1'b0;
      p = (k - 1) % (2 * n + 4);
      return (p < 2 * n) && (p % 2 == 0);
   endfunction

   function automatic logic [NL-1:0] exp_led();
      logic [NL-1:0] v;
      v    = '0;
      v[0] = (m_cyc % 64) >= 32;
      v[1] = m_alive;
      v[2] = (m_state == 1) || (m_state == 2 && blink_exp(m_ticks, m_code[3:0]));
      for (int k = 3; k < NL; k++) v[k] = (m_state != 0) ? m_code[k-3] : 1'b0;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      chk("state_o", 32'(state_o), 32'(m_state));
      chk("exit_value_o", 32'(exit_value_o), 32'((m_state != 0) ? m_code[0] : 1'b0));
      chk("tick_o", 32'(tick_o), 32'((m_cyc % 16) == 15));
`ifndef LED_PWM_DIM_EN
      chk("led_o", 32'(led_o), 32'(exp_led()));
`endif
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         check_cycle();
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step(1);
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      step(3);
      chk("rst_led", 32'(led_o), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      rst_n = 1'b1;

      // Idle: heartbeat and alive LED
      step(128);
      chk("idle_state", 32'(state_o), 32'd0);
      chk("idle_alive", 32'(led_o[1]), 32'd1);

      // PASS on zero exit code
      exit_value = '0;
      exit_valid = 1'b1;
      step(1);
      chk("pass_state", 32'(state_o), 32'd1);
      chk("pass_exit", 32'(exit_value_o), 32'd0);
`ifndef LED_PWM_DIM_EN
      chk("pass_led2", 32'(led_o[2]), 32'd1);
`else
      duty = '0;
      step(2);
      chk("pwm_off", 32'(led_o), 32'd0);
      duty = '1;
`endif
      step(40);
      exit_valid = 1'b0;
      step(3);
      exit_value = 32'h9;
      exit_valid = 1'b1;
      step(20);
      chk("pass_sticky", 32'(state_o), 32'd1);
      pulse_clear();

      // FAIL with code 5
      exit_valid = 1'b0;
      step(2);
      exit_value = 32'h5;
      exit_valid = 1'b1;
      step(1);
      chk("fail5_state", 32'(state_o), 32'd2);
      chk("fail5_exit", 32'(exit_value_o), 32'd1);
      chk("fail5_code", 32'(led_o[5:3]), 32'h5);
      step(470);
      pulse_clear();

      // FAIL with code 0x10: 16 pulses, later rises ignored
      exit_valid = 1'b0;
      step(2);
      exit_value = 32'h10;
      exit_valid = 1'b1;
      step(1);
      chk("fail16_state", 32'(state_o), 32'd2);
      chk("fail16_code", 32'(led_o[5:3]), 32'h0);
      step(300);
      exit_valid = 1'b0;
      step(5);
      exit_value = '0;
      exit_valid = 1'b1;
      step(320);
      chk("fail16_sticky", 32'(state_o), 32'd2);

      // Random exit codes with random valid toggles
      for (int it = 0; it < 6; it++) begin
         pulse_clear();
         exit_valid = 1'b0;
         step(1 + $urandom_range(0, 3));
         exit_value = ($urandom_range(0, 3) == 0) ? '0 : EW'($urandom);
         exit_valid = 1'b1;
         for (int j = 0; j < 3; j++) begin
            step($urandom_range(60, 260));
            if ($urandom_range(0, 1) == 1) exit_valid = ~exit_valid;
            if ($urandom_range(0, 1) == 1) exit_value = EW'($urandom);
         end
      end

      // clear_i wins over a simultaneous rise
      clear      = 1'b1;
      exit_valid = 1'b0;
      step(1);
      clear = 1'b0;
      step(2);
      exit_value = 32'h7;
      exit_valid = 1'b1;
      clear      = 1'b1;
      step(1);
      clear = 1'b0;
      chk("clr_rise_state", 32'(state_o), 32'd0);
`ifndef LED_PWM_DIM_EN
      chk("clr_rise_led", 32'(led_o[5:2]), 32'd0);
`endif
      step(20);

      // Async reset mid-blink
      exit_valid = 1'b0;
      step(2);
      exit_value = 32'h3;
      exit_valid = 1'b1;
      step(100);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_led", 32'(led_o), 32'd0);
      chk("arst_state", 32'(state_o), 32'd0);
      chk("arst_exit", 32'(exit_value_o), 32'd0);
      chk("arst_tick", 32'(tick_o), 32'd0);
      step(2);
      rst_n = 1'b1;
      step(150);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
